// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtract/complement engine.
// Build option: SERIAL_SUB_OVF_EN compiles in signed-overflow tracking.
package serial_sub_pkg;

    localparam int unsigned SS_MIN_WIDTH = 2;
    localparam int unsigned SS_MAX_WIDTH = 32;

    // Operation select, latched together with start
    typedef enum logic [1:0] {
        MODE_SUB  = 2'b00,  // a - b
        MODE_ONES = 2'b01,  // ~a
        MODE_TWOS = 2'b10,  // -a
        MODE_RSUB = 2'b11   // b - a
    } mode_t;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow-out.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow of a single bit position
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_sub_unit.sv
// Bit-serial subtract/complement engine: A-B, B-A, ~A or -A computed LSB
// first over WIDTH cycles through a single full_sub cell.
// Build option: SERIAL_SUB_OVF_EN adds signed-overflow tracking; when it is
// not defined the overflow port is tied low.
module serial_sub_unit
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] rs;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] ld_x;
    logic [WIDTH-1:0] ld_y;

`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_pend;
`endif

    full_sub u_cell (
        .x    (xs[0]),
        .y    (ys[0]),
        .bin  (bin),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Map the requested operation onto the minuend/subtrahend pair
    always_comb begin
        ld_x = a;
        ld_y = b;
        case (mode_t'(mode))
            MODE_SUB:  begin ld_x = a;  ld_y = b; end
            MODE_ONES: begin ld_x = '1; ld_y = a; end
            MODE_TWOS: begin ld_x = '0; ld_y = a; end
            MODE_RSUB: begin ld_x = b;  ld_y = a; end
            default:   begin ld_x = a;  ld_y = b; end
        endcase
    end

`ifndef SERIAL_SUB_OVF_EN
    assign overflow = 1'b0;
`endif

    // Sequencer, datapath shift registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            borrow <= 1'b0;
            xs     <= '0;
            ys     <= '0;
            rs     <= '0;
            cnt    <= '0;
            bin    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            overflow <= 1'b0;
            ovf_pend <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        xs    <= ld_x;
                        ys    <= ld_y;
                        cnt   <= '0;
                        bin   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    xs  <= {1'b0, xs[WIDTH-1:1]};
                    ys  <= {1'b0, ys[WIDTH-1:1]};
                    rs  <= {cell_d, rs[WIDTH-1:1]};
                    bin <= cell_bout;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_DONE;
`ifdef SERIAL_SUB_OVF_EN
                        // MSB is in the cell this cycle: capture its sign relation
                        ovf_pend <= (xs[0] != ys[0]) && (cell_d != xs[0]);
`endif
                    end
                end
                ST_DONE: begin
                    // Outputs publish only here, so partial results never show
                    result <= rs;
                    borrow <= bin;
                    done   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    overflow <= ovf_pend;
`endif
                    if (start) begin
                        xs    <= ld_x;
                        ys    <= ld_y;
                        cnt   <= '0;
                        bin   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_unit.sv
// Scoreboard bench for serial_sub_unit (WIDTH=8): directed vectors push
// expected responses, a monitor pops and compares on every done pulse.
module tb_serial_sub_unit;

    localparam int unsigned W = 8;
`ifdef SERIAL_SUB_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         borrow;
    logic         overflow;

    typedef struct {
        logic [W-1:0] r;
        logic         br;
        logic         ov;
        int           due;
        string        name;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    serial_sub_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .borrow   (borrow),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
                end else begin
                    e = sbq.pop_front();
                    check({e.name, "_result"},   32'(result),   32'(e.r));
                    check({e.name, "_borrow"},   32'(borrow),   32'(e.br));
                    check({e.name, "_overflow"}, 32'(overflow), 32'(e.ov));
                    check({e.name, "_latency"},  32'(cyc),      32'(e.due));
                end
            end
        end
    end

    task automatic push(input string name, input logic [W-1:0] r, input logic br,
                        input logic ov, input int due);
        exp_t e;
        e.r = r; e.br = br; e.ov = ov; e.due = due; e.name = name;
        sbq.push_back(e);
    endtask

    // Issue one op at a negedge; done is expected WIDTH+1 edges after the accepting edge
    task automatic run_op(input string name, input logic [1:0] m, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input logic [W-1:0] r, input logic br,
                          input logic ov);
        @(negedge clk);
        mode = m; a = xa; b = xb; start = 1'b1;
        push(name, r, br, ov, cyc + 1 + W + 1);
        @(negedge clk);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_result",   32'(result),   32'd0);
        check("rst_borrow",   32'(borrow),   32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        // First op done by hand to also check busy timing
        @(negedge clk);
        mode = 2'b00; a = 8'h35; b = 8'h12; start = 1'b1;
        push("sub35_12", 8'h23, 1'b0, 1'b0, cyc + 1 + W + 1);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        repeat (W - 1) @(negedge clk);
        check("busy_last_edge", 32'(busy), 32'd1);
        check("no_early_result", 32'(result), 32'd0);
        repeat (3) @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);

        run_op("sub12_35",  2'b00, 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
        run_op("rsub12_35", 2'b11, 8'h12, 8'h35, 8'h23, 1'b0, 1'b0);
        run_op("ones5a",    2'b01, 8'h5A, 8'hFF, 8'hA5, 1'b0, 1'b0);
        run_op("twos01",    2'b10, 8'h01, 8'h33, 8'hFF, 1'b1, 1'b0);
        run_op("twos00",    2'b10, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op("sub80_01",  2'b00, 8'h80, 8'h01, 8'h7F, 1'b0, OVF_ON);
        run_op("twos80",    2'b10, 8'h80, 8'h00, 8'h80, 1'b1, OVF_ON);

        // Extra start in RUN cycle 3 must be ignored
        @(negedge clk);
        mode = 2'b00; a = 8'h40; b = 8'h05; start = 1'b1;
        push("ignore_start", 8'h3B, 1'b0, 1'b0, cyc + 1 + W + 1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        mode = 2'b01; a = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_during_run", 32'(result), 32'h80);
        repeat (W + 4) @(negedge clk);
        check("ignored_idle", 32'(busy), 32'd0);

        // Back-to-back: start held through DONE, second operands sampled there
        @(negedge clk);
        mode = 2'b00; a = 8'h35; b = 8'h12; start = 1'b1;
        push("b2b_first",  8'h23, 1'b0, 1'b0, cyc + 1 + W + 1);
        push("b2b_second", 8'hDD, 1'b1, 1'b0, cyc + 1 + 2 * (W + 1));
        @(negedge clk);
        a = 8'h12; b = 8'h35;
        repeat (W + 1) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_hold", 32'(result), 32'h23);
        check("b2b_busy", 32'(busy), 32'd1);
        repeat (W) @(negedge clk);

        // Reset at RUN cycle 4 clears outputs without a clock edge
        @(negedge clk);
        mode = 2'b00; a = 8'h77; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_done",   32'(done),   32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("after_reset", 2'b00, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence itself stalls
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_sub_unit.md
# serial_sub_unit

Bit-serial, parametrised subtract/complement engine that succeeds the combinational half-subtractor and one's/two's complement lab blocks. It computes A−B, B−A, ~A or −A over WIDTH clock cycles using one full-subtractor bit cell, with a start/busy/done handshake. It sits between the switch-input register stage and the LED/display output stage in the board top level.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- mode  input  2  operation, latched with start: 00 SUB (A−B), 01 ONES (~A), 10 TWOS (−A), 11 RSUB (B−A)
- a  input  WIDTH  operand A, latched with start
- b  input  WIDTH  operand B, latched with start; ignored for ONES/TWOS
- busy  output  1  high while the serial computation runs
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  last completed result, held until the next completion
- borrow  output  1  final borrow-out of the MSB, held with result
- overflow  output  1  signed overflow of the last result (see Configuration)

## Operation
- Every mode is x − y − bin, LSB first, bin=0 at bit 0:
  - SUB: x=a, y=b
  - ONES: x=all-ones, y=a
  - TWOS: x=0, y=a
  - RSUB: x=b, y=a
- Per bit: d = x⊕y⊕bin; bout = (~x&y) | (~(x⊕y)&bin).
- FSM states:
  - IDLE: start=1 latches x/y into shift registers, clears the bit counter and borrow, and goes to RUN.
  - RUN: each cycle shifts one bit in and stores the cell output into an internal result shift register. After bit WIDTH−1 it goes to DONE.
  - DONE: result/borrow/overflow outputs load, done=1 for this cycle only. Goes to RUN if start=1 (new operands latched), otherwise to IDLE.
- start in RUN is ignored; no queuing.
- Bit counter width is $clog2(WIDTH). It wraps to 0 on entering RUN.
- result/borrow/overflow never show partial values. They change only on DONE entry.
- Signed overflow, when enabled: x_msb≠y_msb and d_msb≠x_msb.

## Timing
- Reset values:
  - state=IDLE
  - busy=0, done=0, result=0, borrow=0, overflow=0
  - all shift registers and the counter 0
- start high at edge 0 → busy=1 after edge 0 through edge WIDTH.
- done=1 and outputs valid after edge WIDTH+1. Latency is WIDTH+1 cycles.
- Back-to-back: start held high during DONE gives a new op every WIDTH+1 cycles.
- Reset asserted mid-RUN aborts immediately and returns to reset values. The first start after deassertion is accepted normally.
- start and reset together: reset wins.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - an MSB-sign tracking register and the overflow logic are compiled in
  - overflow reflects the signed overflow of the last result
- Undefined:
  - that logic is omitted
  - the overflow port remains and is tied to 0

## Structure
- Package serial_sub_pkg:
  - mode encodings (SUB/ONES/TWOS/RSUB)
  - FSM state enum (IDLE/RUN/DONE)
  - shared typedefs
- Sub-module full_sub: combinational one-bit full subtractor (x, y, bin → d, bout), instantiated once.
- Top-level board wiring maps switches to a/b/mode and LEDs to result/borrow/done.

## Test plan
- WIDTH=8, SUB a=0x35 b=0x12 → result=0x23, borrow=0, overflow=0. done pulses exactly once, 9 cycles after start.
- SUB a=0x12 b=0x35 → result=0xDD, borrow=1. RSUB with the same operands → 0x23, borrow=0.
- ONES a=0x5A → 0xA5, borrow=0. TWOS a=0x01 → 0xFF, borrow=1. TWOS a=0x00 → 0x00, borrow=0.
- SUB a=0x80 b=0x01 → 0x7F, overflow=1 with SERIAL_SUB_OVF_EN and 0 without. TWOS a=0x80 → 0x80, overflow=1 (macro on).
- start pulsed again at RUN cycle 3 → ignored, only one done. start held high through DONE → second op completes 9 cycles later. result stays unchanged until each DONE.
- reset asserted at RUN cycle 4 → busy/done/result/borrow are 0 in the same cycle, without waiting for a clock edge. The next start with SUB 0x10−0x01 → 0x0F.
